match_pair_filter: RTL and testbench

- Sits directly downstream of the matcher top and consumes its per-pair stream (src/dst coordinate + depth, valid, frame start/end).
- Rejects geometrically implausible or depth-less pairs and buffers the survivors in a FIFO.
- Inserts an end-of-frame marker and presents pairs to the pose-estimation stage over a valid/ready handshake.

---
 rtl/match_pkg.sv | 24 ++
 rtl/match_pair_filter_pair_fifo.sv | 47 ++++
 rtl/match_pair_filter.sv | 125 ++++++++++++
 tb/tb_match_pair_filter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// match_pkg: shared types and helpers for the match pair filter.
// Contents: COOR_W coordinate width, match_pair_t (60-bit pair), fifo_entry_t (eof flag + pair),
//           abs_diff() unsigned magnitude of the signed difference of two coordinates.
package match_pkg;
   localparam int COOR_W = 10;
   typedef struct packed {
      logic [COOR_W-1:0] src_x;
      logic [COOR_W-1:0] src_y;
      logic [COOR_W-1:0] src_d;
      logic [COOR_W-1:0] dst_x;
      logic [COOR_W-1:0] dst_y;
      logic [COOR_W-1:0] dst_d;
   } match_pair_t;
   typedef struct packed {
      logic        eof;
      match_pair_t pair;
   } fifo_entry_t;
   // One extra bit holds the sign, so the magnitude never wraps.
   function automatic logic [COOR_W:0] abs_diff(input logic [COOR_W-1:0] a, input logic [COOR_W-1:0] b);
      logic [COOR_W:0] d;
      d = {1'b0, a} - {1'b0, b};
      return d[COOR_W] ? -d : d;
   endfunction
endpackage

// File: rtl/match_pair_filter_pair_fifo.sv
// pair_fifo: synchronous first-word-fall-through FIFO of fifo_entry_t.
// Ports: i_clk, i_rst_n (async active-low); i_push/i_data write; i_pop read;
//        o_data head entry; o_full, o_empty, o_free (free entries, 0..DEPTH).
// A pop frees its slot in the same cycle, so push+pop at full is accepted.
module pair_fifo
   import match_pkg::*;
#(
   parameter int DEPTH = 128
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  fifo_entry_t              i_data,
   input  logic                     i_pop,
   output fifo_entry_t              o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_free
);
   localparam int AW = $clog2(DEPTH);
   fifo_entry_t     mem_q [DEPTH];
   logic [AW-1:0]   wr_q, rd_q;
   logic [AW:0]     cnt_q;
   logic            push_ok, pop_ok;
   always_comb begin
      o_empty = cnt_q == '0;
      o_full  = cnt_q == (AW+1)'(DEPTH);
      o_free  = (AW+1)'(DEPTH) - cnt_q;
      pop_ok  = i_pop && !o_empty;
      push_ok = i_push && (!o_full || pop_ok);
      o_data  = mem_q[rd_q];
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_q + AW'(push_ok);
         rd_q  <= rd_q + AW'(pop_ok);
         cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
   end
   always_ff @(posedge i_clk) begin
      if (push_ok) mem_q[wr_q] <= i_data;
   end
endmodule

// File: rtl/match_pair_filter.sv
// match_pair_filter: filters matcher pairs, buffers survivors with frame-end markers, FWFT output.
// Ports: i_clk, i_rst_n (async active-low); i_frame_start/i_frame_end/i_valid + src/dst
//        coordinates and depths from the matcher; i_ready from pose estimation;
//        o_valid/o_eof + pair fields (head entry, zero when empty); o_frame_pairs,
//        o_frame_drops (saturating per-frame counters); o_overflow (sticky per frame).
module match_pair_filter
   import match_pkg::*;
#(
   parameter int                DEPTH    = 128,
   parameter logic [COOR_W-1:0] MAX_DISP = 10'd64,
   parameter int                CNT_W    = 12
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_frame_start,
   input  logic              i_frame_end,
   input  logic              i_valid,
   input  logic [COOR_W-1:0] i_src_coor_x,
   input  logic [COOR_W-1:0] i_src_coor_y,
   input  logic [COOR_W-1:0] i_src_depth,
   input  logic [COOR_W-1:0] i_dst_coor_x,
   input  logic [COOR_W-1:0] i_dst_coor_y,
   input  logic [COOR_W-1:0] i_dst_depth,
   input  logic              i_ready,
   output logic              o_valid,
   output logic              o_eof,
   output logic [COOR_W-1:0] o_src_coor_x,
   output logic [COOR_W-1:0] o_src_coor_y,
   output logic [COOR_W-1:0] o_src_depth,
   output logic [COOR_W-1:0] o_dst_coor_x,
   output logic [COOR_W-1:0] o_dst_coor_y,
   output logic [COOR_W-1:0] o_dst_depth,
   output logic [CNT_W-1:0]  o_frame_pairs,
   output logic [CNT_W-1:0]  o_frame_drops,
   output logic              o_overflow
);
   localparam int AW = $clog2(DEPTH);
   logic                 fs_q, fe_q, v_q, pend_q, pend_d, ovf_q, ovf_d;
   match_pair_t          pair_q;
   logic [CNT_W-1:0]     pairs_q, pairs_d, drops_q, drops_d, pairs_base, drops_base;
   logic                 acc, rej, wr_pair, ovf_drop, mk_req, wr_mk, mk_lost, pop, push;
   logic                 full, empty;
   logic [AW:0]          free, free_eff;
   fifo_entry_t          push_data, head;
   // Stage 0: unconditional input register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fs_q   <= 1'b0;
         fe_q   <= 1'b0;
         v_q    <= 1'b0;
         pair_q <= '0;
      end else begin
         fs_q   <= i_frame_start;
         fe_q   <= i_frame_end;
         v_q    <= i_valid;
         pair_q <= '{i_src_coor_x, i_src_coor_y, i_src_depth, i_dst_coor_x, i_dst_coor_y, i_dst_depth};
      end
   end
   // Stage 1: filter, reserve-aware write, marker insertion and per-frame statistics.
   always_comb begin
      pop      = !empty && i_ready;
      free_eff = free + (AW+1)'(pop);
      acc      = v_q && (pair_q.src_d != '0) && (pair_q.dst_d != '0)
                 && abs_diff(pair_q.dst_x, pair_q.src_x) <= {1'b0, MAX_DISP}
                 && abs_diff(pair_q.dst_y, pair_q.src_y) <= {1'b0, MAX_DISP};
      rej      = v_q && !acc;
      // A pair needs two free slots so the frame-end marker always has room.
      wr_pair  = acc && free_eff >= (AW+1)'(2);
      ovf_drop = acc && !wr_pair;
      // A pair owns the single write port; the marker waits in pend_q until the port is idle.
      // A frame end arriving while a marker is already pending merges into it.
      mk_req   = fe_q || pend_q;
      wr_mk    = mk_req && !wr_pair && free_eff != '0;
      mk_lost  = mk_req && !wr_pair && free_eff == '0;
      pend_d   = mk_req && wr_pair;
      push     = wr_pair || wr_mk;
      push_data = wr_pair ? fifo_entry_t'{1'b0, pair_q} : fifo_entry_t'{1'b1, '0};
      // Frame start restarts statistics; a pair in the same cycle lands in the new frame.
      pairs_base = fs_q ? '0 : pairs_q;
      drops_base = fs_q ? '0 : drops_q;
      pairs_d  = pairs_base + CNT_W'(wr_pair && !(&pairs_base));
      drops_d  = drops_base + CNT_W'((rej || ovf_drop) && !(&drops_base));
      ovf_d    = (!fs_q && ovf_q) || ovf_drop || mk_lost;
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pend_q  <= 1'b0;
         ovf_q   <= 1'b0;
         pairs_q <= '0;
         drops_q <= '0;
      end else begin
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         pairs_q <= pairs_d;
         drops_q <= drops_d;
      end
   end
   pair_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (push),
      .i_data  (push_data),
      .i_pop   (pop),
      .o_data  (head),
      .o_full  (full),
      .o_empty (empty),
      .o_free  (free)
   );
   // Head fields are gated so an empty FIFO presents zeros rather than stale memory.
   always_comb begin
      o_valid       = !empty;
      o_eof         = o_valid ? head.eof : 1'b0;
      o_src_coor_x  = o_valid ? head.pair.src_x : '0;
      o_src_coor_y  = o_valid ? head.pair.src_y : '0;
      o_src_depth   = o_valid ? head.pair.src_d : '0;
      o_dst_coor_x  = o_valid ? head.pair.dst_x : '0;
      o_dst_coor_y  = o_valid ? head.pair.dst_y : '0;
      o_dst_depth   = o_valid ? head.pair.dst_d : '0;
      o_frame_pairs = pairs_q;
      o_frame_drops = drops_q;
      o_overflow    = ovf_q;
   end
   logic unused_full;
   assign unused_full = full;
endmodule

// File: tb/tb_match_pair_filter.sv
// tb_match_pair_filter: directed self-checking bench for match_pair_filter (DEPTH=8).
module tb_match_pair_filter;
   logic       i_clk = 1'b0, i_rst_n = 1'b0;
   logic       i_frame_start = 0, i_frame_end = 0, i_valid = 0, i_ready = 0;
   logic [9:0] i_src_coor_x = 0, i_src_coor_y = 0, i_src_depth = 0;
   logic [9:0] i_dst_coor_x = 0, i_dst_coor_y = 0, i_dst_depth = 0;
   logic       o_valid, o_eof, o_overflow;
   logic [9:0] o_src_coor_x, o_src_coor_y, o_src_depth, o_dst_coor_x, o_dst_coor_y, o_dst_depth;
   logic [11:0] o_frame_pairs, o_frame_drops;
   int          n_chk = 0, n_pass = 0;
   logic [60:0] sb[$];

   match_pair_filter #(.DEPTH(8), .MAX_DISP(10'd64), .CNT_W(12)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_start(i_frame_start), .i_frame_end(i_frame_end),
      .i_valid(i_valid), .i_src_coor_x(i_src_coor_x), .i_src_coor_y(i_src_coor_y),
      .i_src_depth(i_src_depth), .i_dst_coor_x(i_dst_coor_x), .i_dst_coor_y(i_dst_coor_y),
      .i_dst_depth(i_dst_depth), .i_ready(i_ready), .o_valid(o_valid), .o_eof(o_eof),
      .o_src_coor_x(o_src_coor_x), .o_src_coor_y(o_src_coor_y), .o_src_depth(o_src_depth),
      .o_dst_coor_x(o_dst_coor_x), .o_dst_coor_y(o_dst_coor_y), .o_dst_depth(o_dst_depth),
      .o_frame_pairs(o_frame_pairs), .o_frame_drops(o_frame_drops), .o_overflow(o_overflow)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic ctl(input bit fs, input bit fe);
      i_frame_start = fs;
      i_frame_end   = fe;
      if (fe) sb.push_back({1'b1, 60'b0});
      idle(1);
      i_frame_start = 0;
      i_frame_end   = 0;
   endtask

   task automatic pair(input logic [9:0] sx, input logic [9:0] sy, input logic [9:0] sd,
                       input logic [9:0] dx, input logic [9:0] dy, input logic [9:0] dd,
                       input bit st, input bit fe);
      {i_src_coor_x, i_src_coor_y, i_src_depth} = {sx, sy, sd};
      {i_dst_coor_x, i_dst_coor_y, i_dst_depth} = {dx, dy, dd};
      i_valid     = 1;
      i_frame_end = fe;
      if (st) sb.push_back({1'b0, sx, sy, sd, dx, dy, dd});
      if (fe) sb.push_back({1'b1, 60'b0});
      idle(1);
      i_valid     = 0;
      i_frame_end = 0;
   endtask

   // Head of the output must always equal the oldest expected entry, stalled or not.
   always @(negedge i_clk) begin
      if (i_rst_n && o_valid) begin
         if (sb.size() == 0) check("extra_out", o_valid, 0);
         else begin
            check("head", {o_eof, o_src_coor_x, o_src_coor_y, o_src_depth,
                           o_dst_coor_x, o_dst_coor_y, o_dst_depth}, sb[0]);
            if (i_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      #2;
      check("rst_valid", o_valid, 0);
      check("rst_eof", o_eof, 0);
      check("rst_pairs", o_frame_pairs, 0);
      check("rst_drops", o_frame_drops, 0);
      check("rst_ovf", o_overflow, 0);
      check("rst_data", {o_src_coor_x, o_dst_depth}, 0);
      @(posedge i_clk);
      #1 i_rst_n = 1;
      // accept path and latency
      i_ready = 1;
      ctl(1, 0);
      pair(100, 50, 200, 110, 45, 190, 1, 0);
      @(negedge i_clk);
      check("lat_n1", o_valid, 0);
      @(posedge i_clk);
      #1;
      @(negedge i_clk);
      check("lat_n2", o_valid, 1);
      check("acc_eof", o_eof, 0);
      idle(2);
      check("acc_pairs", o_frame_pairs, 1);
      // filter
      ctl(1, 0);
      pair(100, 100, 0, 100, 100, 50, 0, 0);
      pair(100, 100, 50, 165, 100, 50, 0, 0);
      pair(100, 100, 50, 100, 35, 50, 0, 0);
      pair(100, 100, 50, 164, 100, 50, 1, 0);
      idle(3);
      check("flt_drops", o_frame_drops, 3);
      check("flt_pairs", o_frame_pairs, 1);
      check("flt_ovf", o_overflow, 0);
      // frame end after pairs, then coincident with the last pair
      ctl(1, 0);
      pair(1, 2, 3, 4, 5, 6, 1, 0);
      pair(7, 8, 9, 10, 11, 12, 1, 0);
      pair(13, 14, 15, 16, 17, 18, 1, 0);
      ctl(0, 1);
      idle(4);
      check("fe_pairs", o_frame_pairs, 3);
      check("fe_drain", sb.size(), 0);
      ctl(1, 0);
      pair(21, 22, 23, 24, 25, 26, 1, 0);
      pair(31, 32, 33, 34, 35, 36, 1, 0);
      pair(41, 42, 43, 44, 45, 46, 1, 1);
      idle(4);
      check("fec_pairs", o_frame_pairs, 3);
      check("fec_drain", sb.size(), 0);
      // overflow with reserved marker slot
      i_ready = 0;
      ctl(1, 0);
      for (int i = 0; i < 10; i++)
         pair(10'(i * 10 + 1), 20, 30, 10'(i * 10 + 5), 22, 31, i < 7, 0);
      ctl(0, 1);
      idle(3);
      check("ovf_pairs", o_frame_pairs, 7);
      check("ovf_drops", o_frame_drops, 3);
      check("ovf_flag", o_overflow, 1);
      check("ovf_valid", o_valid, 1);
      i_ready = 1;
      idle(10);
      check("ovf_empty", o_valid, 0);
      check("ovf_drain", sb.size(), 0);
      // backpressure
      ctl(1, 0);
      for (int i = 0; i < 20; i++) begin
         i_ready = 1;
         pair(10'(i * 13), 10'(i * 7 + 3), 10'(i + 1), 10'(i * 14), 10'(i * 9 + 3), 10'(i + 2), 1, 0);
         i_ready = 0;
         idle(1);
      end
      i_ready = 1;
      ctl(0, 1);
      idle(4);
      check("bp_pairs", o_frame_pairs, 20);
      check("bp_drops", o_frame_drops, 0);
      check("bp_ovf", o_overflow, 0);
      check("bp_drain", sb.size(), 0);
      // reset mid-frame
      i_ready = 0;
      ctl(1, 0);
      for (int i = 0; i < 5; i++) pair(10'(i + 50), 60, 70, 10'(i + 52), 61, 72, 1, 0);
      idle(2);
      @(negedge i_clk);
      check("mid_valid_pre", o_valid, 1);
      @(posedge i_clk);
      #1 i_rst_n = 0;
      sb.delete();
      #2;
      check("mid_valid", o_valid, 0);
      check("mid_pairs", o_frame_pairs, 0);
      check("mid_drops", o_frame_drops, 0);
      @(posedge i_clk);
      #1 i_rst_n = 1;
      i_ready = 1;
      idle(4);
      check("mid_no_eof", o_valid, 0);
      ctl(1, 0);
      pair(5, 5, 5, 6, 6, 6, 1, 0);
      ctl(0, 1);
      idle(4);
      check("post_pairs", o_frame_pairs, 1);
      check("post_drain", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
